// File: rtl/gray_seg_scan_ctrl.sv
// Scan controller for a multiplexed octal 7-segment display. Each digit gets a PRESCALE-cycle
// slot: BLANK dead cycles, then lit. The stored 3-bit Gray values feed one shared converter.
module gray_seg_scan_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int DW         = $clog2(NUM_DIGITS),
  parameter int PRESCALE   = 8,
  parameter int BLANK      = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  wr_valid,
  input  logic [DW-1:0]         wr_digit,
  input  logic [2:0]            wr_g,
  output logic                  wr_ready,
  output logic [2:0]            g_out,
  output logic [NUM_DIGITS-1:0] dig_en,
  output logic                  blank,
  output logic                  frame_done
);

  localparam int CW = $clog2(PRESCALE);
  localparam logic [CW-1:0] CNT_LAST   = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK > 0) ? BLANK - 1 : 0);
  localparam logic [DW-1:0] CUR_LAST   = DW'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_BLANK, ST_SHOW} state_e;

  // With no dead-time a slot opens directly in SHOW.
  localparam state_e SLOT_START = (BLANK == 0) ? ST_SHOW : ST_BLANK;

  state_e                      state_q, state_d;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic [DW-1:0]               cur_q, cur_d;
  logic [NUM_DIGITS-1:0][2:0]  digit_q, digit_d;
  logic [2:0]                  g_out_q, g_out_d;
  logic [NUM_DIGITS-1:0]       dig_en_q, dig_en_d;
  logic                        blank_q, blank_d;
  logic                        frame_done_q, frame_done_d;
  logic                        slot_end;

  // The lit digit's register is frozen so the displayed value cannot tear.
  assign wr_ready = !((state_q == ST_SHOW) && (wr_digit == cur_q));
  assign slot_end = (state_q == ST_SHOW) && (cnt_q == CNT_LAST);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    cur_d        = cur_q;
    digit_d      = digit_q;
    frame_done_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (en) begin
          state_d = SLOT_START;
          cnt_d   = '0;
          cur_d   = '0;
        end
      end
      ST_BLANK: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == BLANK_LAST) state_d = ST_SHOW;
      end
      ST_SHOW: begin
        if (slot_end) begin
          cnt_d        = '0;
          frame_done_d = (cur_q == CUR_LAST);
          if (en) begin
            state_d = SLOT_START;
            cur_d   = (cur_q == CUR_LAST) ? '0 : cur_q + 1'b1;
          end else begin
            state_d = ST_IDLE;
            cur_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Out-of-range indices match no register and are silently dropped.
    if (wr_valid && wr_ready) begin
      for (int i = 0; i < NUM_DIGITS; i++)
        if (wr_digit == DW'(i)) digit_d[i] = wr_g;
    end

    g_out_d  = '0;
    dig_en_d = '0;
    blank_d  = (state_d != ST_SHOW);
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (cur_d == DW'(i)) begin
        if (state_d != ST_IDLE) g_out_d = digit_d[i];
        dig_en_d[i] = (state_d == ST_SHOW);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      cur_q        <= '0;
      digit_q      <= '0;
      g_out_q      <= '0;
      dig_en_q     <= '0;
      blank_q      <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cur_q        <= cur_d;
      digit_q      <= digit_d;
      g_out_q      <= g_out_d;
      dig_en_q     <= dig_en_d;
      blank_q      <= blank_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign g_out      = g_out_q;
  assign dig_en     = dig_en_q;
  assign blank      = blank_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_gray_seg_scan_ctrl.sv
// Directed bench: main build (4 digits, BLANK=2), a BLANK=0 build and a 3-digit build.
module tb_gray_seg_scan_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // main build
  logic       rst_n, en, wr_valid, wr_ready, blank, frame_done;
  logic [1:0] wr_digit;
  logic [2:0] wr_g, g_out;
  logic [3:0] dig_en;
  // BLANK=0 build
  logic       b_rst_n, b_en, b_wr_valid, b_wr_ready, b_blank, b_frame_done;
  logic [1:0] b_wr_digit;
  logic [2:0] b_wr_g, b_g_out;
  logic [3:0] b_dig_en;
  // 3-digit build
  logic       n_rst_n, n_en, n_wr_valid, n_wr_ready, n_blank, n_frame_done;
  logic [1:0] n_wr_digit;
  logic [2:0] n_wr_g, n_g_out;
  logic [2:0] n_dig_en;

  gray_seg_scan_ctrl #(.NUM_DIGITS(4), .DW(2), .PRESCALE(8), .BLANK(2)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .wr_valid(wr_valid), .wr_digit(wr_digit),
    .wr_g(wr_g), .wr_ready(wr_ready), .g_out(g_out), .dig_en(dig_en),
    .blank(blank), .frame_done(frame_done));

  gray_seg_scan_ctrl #(.NUM_DIGITS(4), .DW(2), .PRESCALE(8), .BLANK(0)) dut_b0 (
    .clk(clk), .rst_n(b_rst_n), .en(b_en), .wr_valid(b_wr_valid), .wr_digit(b_wr_digit),
    .wr_g(b_wr_g), .wr_ready(b_wr_ready), .g_out(b_g_out), .dig_en(b_dig_en),
    .blank(b_blank), .frame_done(b_frame_done));

  gray_seg_scan_ctrl #(.NUM_DIGITS(3), .DW(2), .PRESCALE(8), .BLANK(2)) dut_n3 (
    .clk(clk), .rst_n(n_rst_n), .en(n_en), .wr_valid(n_wr_valid), .wr_digit(n_wr_digit),
    .wr_g(n_wr_g), .wr_ready(n_wr_ready), .g_out(n_g_out), .dig_en(n_dig_en),
    .blank(n_blank), .frame_done(n_frame_done));

  int         total = 0;
  int         bad   = 0;
  int         t     = 0;     // cycles since the edge before the one that sampled en=1
  bit         track = 1'b0;  // compare main build against the slot model every cycle
  logic [2:0] expv [4];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0d", tag, got, exp, t);
    end
  endtask

  // Slot model: k-th cycle of the scan, 8 cycles per slot, first 2 blanked.
  task automatic step();
    int k, p, d;
    @(posedge clk); #1;
    if (track) begin
      t++;
      k = t - 1; p = k % 8; d = (k / 8) % 4;
      chk("dig_en", {28'd0, dig_en}, (p >= 2) ? (32'd1 << d) : 32'd0);
      chk("blank", {31'd0, blank}, {31'd0, p < 2});
      chk("g_out", {29'd0, g_out}, {29'd0, expv[d]});
      chk("frame_done", {31'd0, frame_done}, {31'd0, (k > 0) && (k % 32 == 0)});
    end
  endtask

  task automatic goto(input int d, input int p);
    int n = 0;
    while (!(((t - 1) % 8) == p && (((t - 1) / 8) % 4) == d) && n < 64) begin
      step();
      n++;
    end
    chk("goto_bound", {31'd0, n < 64}, 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int k, d, p;
    rst_n = 1'b0; en = 1'b1; wr_valid = 1'b1; wr_digit = 2'd0; wr_g = 3'd5;
    b_rst_n = 1'b0; b_en = 1'b0; b_wr_valid = 1'b0; b_wr_digit = 2'd0; b_wr_g = 3'd0;
    n_rst_n = 1'b0; n_en = 1'b0; n_wr_valid = 1'b0; n_wr_digit = 2'd0; n_wr_g = 3'd0;
    for (int i = 0; i < 4; i++) expv[i] = 3'd0;

    // reset dominates en and a pending write
    repeat (3) step();
    chk("rst_g_out", {29'd0, g_out}, 32'd0);
    chk("rst_dig_en", {28'd0, dig_en}, 32'd0);
    chk("rst_blank", {31'd0, blank}, 32'd1);
    chk("rst_frame_done", {31'd0, frame_done}, 32'd0);

    // scan order, timing and frame_done over two frames
    rst_n = 1'b1; wr_valid = 1'b0; track = 1'b1;
    repeat (66) step();

    // write to a non-lit digit during digit 0 SHOW
    goto(0, 2);
    wr_valid = 1'b1; wr_digit = 2'd1; wr_g = 3'd3; #1;
    chk("rdy_nonactive", {31'd0, wr_ready}, 32'd1);
    step();
    wr_valid = 1'b0; expv[1] = 3'd3;
    wr_digit = 2'd0; #1;
    chk("rdy_active", {31'd0, wr_ready}, 32'd0);
    goto(1, 7);

    // stalled write to the lit digit, accepted on the next slot's blank
    goto(2, 3);
    wr_valid = 1'b1; wr_digit = 2'd2; wr_g = 3'd6; #1;
    repeat (5) begin
      chk("stall", {31'd0, wr_ready}, 32'd0);
      step();
    end
    chk("stall_release", {31'd0, wr_ready}, 32'd1);
    step();
    wr_valid = 1'b0; expv[2] = 3'd6;
    goto(2, 7);

    // en drop mid-slot: slot completes, then idle, then restart at digit 0
    goto(1, 4);
    en = 1'b0;
    goto(1, 7);
    track = 1'b0;
    step();
    chk("idle_dig_en", {28'd0, dig_en}, 32'd0);
    chk("idle_blank", {31'd0, blank}, 32'd1);
    chk("idle_frame_done", {31'd0, frame_done}, 32'd0);
    repeat (3) step();
    chk("idle_hold_dig_en", {28'd0, dig_en}, 32'd0);
    chk("idle_hold_blank", {31'd0, blank}, 32'd1);
    en = 1'b1; t = 0; track = 1'b1;
    goto(0, 2);

    // reset mid-scan clears digits and blanks at once
    goto(1, 3);
    rst_n = 1'b0; track = 1'b0;
    step();
    chk("midrst_blank", {31'd0, blank}, 32'd1);
    chk("midrst_dig_en", {28'd0, dig_en}, 32'd0);
    chk("midrst_g_out", {29'd0, g_out}, 32'd0);
    chk("midrst_frame_done", {31'd0, frame_done}, 32'd0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) expv[i] = 3'd0;
    t = 0; track = 1'b1;
    goto(3, 7);

    // BLANK=0 build: always lit, 8 cycles per digit
    b_rst_n = 1'b1; b_en = 1'b1;
    for (int tb = 1; tb <= 40; tb++) begin
      step();
      k = tb - 1; d = (k / 8) % 4;
      chk("b0_dig_en", {28'd0, b_dig_en}, 32'd1 << d);
      chk("b0_blank", {31'd0, b_blank}, 32'd0);
      chk("b0_frame_done", {31'd0, b_frame_done}, {31'd0, k == 32});
    end

    // 3-digit build: idle writes, out-of-range index discarded
    n_rst_n = 1'b1;
    step();
    n_wr_valid = 1'b1; n_wr_digit = 2'd3; n_wr_g = 3'd7; #1;
    chk("n3_rdy_oor", {31'd0, n_wr_ready}, 32'd1);
    step();
    n_wr_digit = 2'd1; n_wr_g = 3'd5; #1;
    chk("n3_rdy_idle", {31'd0, n_wr_ready}, 32'd1);
    step();
    n_wr_valid = 1'b0; n_en = 1'b1;
    for (int tn = 1; tn <= 26; tn++) begin
      step();
      k = tn - 1; p = k % 8; d = (k / 8) % 3;
      chk("n3_dig_en", {29'd0, n_dig_en}, (p >= 2) ? (32'd1 << d) : 32'd0);
      chk("n3_g_out", {29'd0, n_g_out}, (d == 1) ? 32'd5 : 32'd0);
      chk("n3_frame_done", {31'd0, n_frame_done}, {31'd0, k == 24});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
